data_mem_responder: RTL

- Responder for load/store requests issued by the MEMORYACCESS stage of the pipelined core.
- Holds a word-organised data RAM and decodes RISC-V load/store size and sign from funct3.
- Returns one response per accepted request after one cycle, with a one-entry response register under valid/ready backpressure.
- Flags misaligned, out-of-range and illegal-funct3 accesses instead of performing them.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/dmem_lane_align.sv | 57 +++++
 rtl/data_mem_responder.sv | 111 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: data width, load/store funct3 encodings and access-size decode.
package cpu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      MEM_B  = 3'd0,
      MEM_H  = 3'd1,
      MEM_W  = 3'd2,
      MEM_BU = 3'd4,
      MEM_HU = 3'd5
   } mem_funct3_e;

   // Access size in bytes; 0 marks an encoding with no legal load size.
   function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
      case (funct3)
         3'd0, 3'd4: access_bytes = 3'd1;
         3'd1, 3'd5: access_bytes = 3'd2;
         3'd2:       access_bytes = 3'd4;
         default:    access_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane placement for stores and lane extract/extend for loads (combinational).
module dmem_lane_align
   import cpu_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rword,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wlane,
   output logic [XLEN-1:0] ldata
);

   logic [XLEN-1:0] byte_sh_s;
   logic [XLEN-1:0] half_sh_s;

   assign byte_sh_s = rword >> {addr_lo, 3'b000};
   assign half_sh_s = rword >> {addr_lo[1], 4'b0000};

   // Store data is replicated to every lane; byte enables pick the live ones.
   always_comb begin
      be    = 4'b0000;
      wlane = wdata;
      case (access_bytes(funct3))
         3'd1: begin
            be    = 4'b0001 << addr_lo;
            wlane = {4{wdata[7:0]}};
         end
         3'd2: begin
            be    = 4'b0011 << {addr_lo[1], 1'b0};
            wlane = {2{wdata[15:0]}};
         end
         3'd4: begin
            be    = 4'b1111;
            wlane = wdata;
         end
         default: begin
            be    = 4'b0000;
            wlane = wdata;
         end
      endcase
   end

   // Load extract and sign/zero extension.
   always_comb begin
      ldata = {XLEN{1'b0}};
      case (mem_funct3_e'(funct3))
         MEM_B:   ldata = {{24{byte_sh_s[7]}}, byte_sh_s[7:0]};
         MEM_BU:  ldata = {24'h000000, byte_sh_s[7:0]};
         MEM_H:   ldata = {{16{half_sh_s[15]}}, half_sh_s[15:0]};
         MEM_HU:  ldata = {16'h0000, half_sh_s[15:0]};
         MEM_W:   ldata = rword;
         default: ldata = {XLEN{1'b0}};
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder with word RAM, access checks and a one-entry response register.
// Optional DMEM_STATS_EN adds saturating load/store/error counters.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int XLEN        = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [31:0]     req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0]     stat_loads,
   output logic [15:0]     stat_stores,
   output logic [15:0]     stat_errs
`endif
);
   import cpu_pkg::*;

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [XLEN-1:0] mem_r [DEPTH_WORDS];

   logic            accept_s;
   logic [2:0]      size_s;
   logic            misalign_s;
   logic            range_s;
   logic            illegal_s;
   logic            err_s;
   logic [AW-1:0]   idx_s;
   logic [XLEN-1:0] rword_s;
   logic [3:0]      be_s;
   logic [XLEN-1:0] wlane_s;
   logic [XLEN-1:0] ldata_s;

   assign req_ready  = rst && (!rsp_valid || rsp_ready);
   assign accept_s   = req_valid && req_ready;
   assign size_s     = access_bytes(req_funct3);
   assign misalign_s = ((size_s == 3'd2) && req_addr[0]) ||
                       ((size_s == 3'd4) && (req_addr[1:0] != 2'b00));
   assign range_s    = (req_addr[31:2] >= 30'(DEPTH_WORDS));
   assign illegal_s  = req_we ? (req_funct3 > 3'd2) : (size_s == 3'd0);
   assign err_s      = misalign_s || range_s || illegal_s;
   assign idx_s      = req_addr[AW+1:2];
   // Out-of-range indices never touch the array, so no aliasing is possible.
   assign rword_s    = range_s ? {XLEN{1'b0}} : mem_r[idx_s];

   dmem_lane_align u_align (
      .funct3  (req_funct3),
      .addr_lo (req_addr[1:0]),
      .wdata   (req_wdata),
      .rword   (rword_s),
      .be      (be_s),
      .wlane   (wlane_s),
      .ldata   (ldata_s)
   );

   // Byte-lane store into the RAM, committed at the accept edge.
   always_ff @(posedge clk) begin
      if (accept_s && req_we && !err_s) begin
         for (int b = 0; b < 4; b++) begin
            if (be_s[b]) begin
               mem_r[idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
            end
         end
      end
   end

   // Response register: load on accept, clear on drain, hold while stalled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= {XLEN{1'b0}};
         rsp_err   <= 1'b0;
      end else if (accept_s) begin
         rsp_valid <= 1'b1;
         rsp_err   <= err_s;
         rsp_rdata <= (err_s || req_we) ? {XLEN{1'b0}} : ldata_s;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

`ifdef DMEM_STATS_EN
   // Saturating access counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_loads  <= 16'h0000;
         stat_stores <= 16'h0000;
         stat_errs   <= 16'h0000;
      end else if (accept_s) begin
         if (err_s) begin
            if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'h0001;
         end else if (req_we) begin
            if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'h0001;
         end else begin
            if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'h0001;
         end
      end
   end
`endif

endmodule
